// File: rtl/sram_rmw_ctrl_if.sv
// Upstream byte-enabled request bus between the cache/core side (master)
// and the read-modify-write adapter (slave).
interface sram_rmw_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  req_i;
  logic                  gnt_o;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [BE_WIDTH-1:0]   be_i;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sram_rmw_ctrl.sv
// Turns partial byte-enabled writes into read + merged full-word write for an SRAM without byte enables.
// Optional partial-write counter on rmw_cnt_o is built only when SRAM_RMW_CNT_EN is defined.
module sram_rmw_ctrl #(
  parameter int  DATA_WIDTH = 64,
  parameter int  NUM_WORDS  = 256,
  localparam int BE_WIDTH   = DATA_WIDTH / 8,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_rmw_ctrl_if.slave        up,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BE_WIDTH-1:0]   sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic [31:0]           rmw_cnt_o
);

  typedef enum logic {IDLE, MERGE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  gnt;
  logic                  accept;
  logic                  be_full;
  logic                  be_none;
  logic                  partial;
  logic [DATA_WIDTH-1:0] merged;

  assign gnt     = (state_q == IDLE) && !rst_i;
  assign accept  = up.req_i && gnt;
  assign be_full = (up.be_i == {BE_WIDTH{1'b1}});
  assign be_none = (up.be_i == '0);
  assign partial = up.we_i && !be_full && !be_none;

  always_comb begin
    merged = sram_rdata_i;
    for (int k = 0; k < BE_WIDTH; k++) begin
      if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

  // A partial write issues a plain read in IDLE; the merge happens against the returning word.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = up.addr_i;
    sram_wdata_o = up.wdata_i;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (up.req_i && !(up.we_i && be_none)) begin
            sram_req_o = 1'b1;
            sram_we_o  = up.we_i && be_full;
          end
        end
        MERGE: begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = addr_q;
          sram_wdata_o = merged;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= accept && !up.we_i;
      if (rvalid_q) rdata_q <= sram_rdata_i;
      case (state_q)
        IDLE: begin
          if (accept && partial) begin
            addr_q  <= up.addr_i;
            wdata_q <= up.wdata_i;
            be_q    <= up.be_i;
            state_q <= MERGE;
          end
        end
        MERGE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign up.gnt_o    = gnt;
  assign up.rvalid_o = rvalid_q;
  // Read data is forwarded straight from the SRAM and held once the pulse ends.
  assign up.rdata_o  = rvalid_q ? sram_rdata_i : rdata_q;
  assign sram_be_o   = {BE_WIDTH{1'b1}};

`ifdef SRAM_RMW_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept && partial && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign rmw_cnt_o = cnt_q;
`else
  assign rmw_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Directed bench for sram_rmw_ctrl with a behavioural 1-cycle-latency SRAM model.
module tb_sram_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_req, sram_we;
  logic [7:0]  sram_addr, sram_be;
  logic [63:0] sram_wdata, sram_rdata;
  logic [31:0] rmw_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int sram_wr_cnt = 0;

  logic [63:0] mem [256];

  sram_rmw_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) bus ();

  sram_rmw_ctrl #(.DATA_WIDTH(64), .NUM_WORDS(256)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .up           (bus),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata),
    .rmw_cnt_o    (rmw_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        sram_wr_cnt    <= sram_wr_cnt + 1;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        exp_req;
    logic        exp_we;
    logic        exp_rmw;
    logic [63:0] exp_dat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_model(input int n);
`ifdef SRAM_RMW_CNT_EN
    return 32'(n);
`else
    return 32'h0;
`endif
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.req_i   = 1'b1;
    bus.we_i    = v.we;
    bus.addr_i  = v.addr;
    bus.wdata_i = v.wdata;
    bus.be_i    = v.be;
    #1;
    chk("gnt_idle", 64'(bus.gnt_o), 64'h1);
    chk("sram_req", 64'(sram_req), 64'(v.exp_req));
    chk("sram_be", 64'(sram_be), 64'hFF);
    if (v.exp_req) begin
      chk("sram_we", 64'(sram_we), 64'(v.exp_we));
      chk("sram_addr", 64'(sram_addr), 64'(v.addr));
      if (v.exp_we) chk("sram_wdata", sram_wdata, v.exp_dat);
    end
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    chk("rvalid", 64'(bus.rvalid_o), 64'(!v.we));
    if (!v.we) chk("rdata", bus.rdata_o, v.exp_dat);
    if (v.exp_rmw) begin
      exp_cnt++;
      @(negedge clk);
      #1;
      chk("gnt_merge", 64'(bus.gnt_o), 64'h0);
      chk("merge_req", 64'(sram_req), 64'h1);
      chk("merge_we", 64'(sram_we), 64'h1);
      chk("merge_addr", 64'(sram_addr), 64'(v.addr));
      chk("merge_wdata", sram_wdata, v.exp_dat);
      @(posedge clk);
      #1;
      chk("gnt_back", 64'(bus.gnt_o), 64'h1);
      chk("rvalid_merge", 64'(bus.rvalid_o), 64'h0);
    end
    chk("rmw_cnt", 64'(rmw_cnt), 64'(cnt_model(exp_cnt)));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int wr_before;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;

    vecs[0]  = '{1'b1, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1]  = '{1'b1, 8'h00, 64'h0, 8'hFF, 1'b1, 1'b1, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 8'h01, 64'h1, 8'hFF, 1'b1, 1'b1, 1'b0, 64'h1};
    vecs[3]  = '{1'b1, 8'h02, 64'h2, 8'hFF, 1'b1, 1'b1, 1'b0, 64'h2};
    vecs[4]  = '{1'b1, 8'h03, 64'h3, 8'hFF, 1'b1, 1'b1, 1'b0, 64'h3};
    vecs[5]  = '{1'b1, 8'h30, 64'hDEAD_BEEF_0000_3030, 8'hFF, 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_3030};
    vecs[6]  = '{1'b1, 8'h40, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1, 1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[7]  = '{1'b1, 8'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[8]  = '{1'b0, 8'h10, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[9]  = '{1'b1, 8'h20, 64'h0, 8'h0F, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000};
    vecs[10] = '{1'b0, 8'h20, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000};
    vecs[11] = '{1'b1, 8'h30, 64'h1111_1111_1111_1111, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[12] = '{1'b0, 8'h30, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_3030};
    vecs[13] = '{1'b1, 8'h20, 64'h1122_3344_5566_7788, 8'hA5, 1'b1, 1'b0, 1'b1, 64'h11FF_33FF_0066_0088};
    vecs[14] = '{1'b0, 8'h20, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 64'h11FF_33FF_0066_0088};

    // Reset state with a request pending on the bus.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(bus.gnt_o), 64'h0);
    chk("rst_sram_req", 64'(sram_req), 64'h0);
    chk("rst_rvalid", 64'(bus.rvalid_o), 64'h0);
    chk("rst_cnt", 64'(rmw_cnt), 64'h0);
    bus.req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_no_req", 64'(sram_req), 64'h0);
    chk("idle_gnt", 64'(bus.gnt_o), 64'h1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Back-to-back reads of addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 8'(i); bus.be_i = 8'h00;
      @(posedge clk);
      #1;
      chk("pipe_rvalid", 64'(bus.rvalid_o), 64'h1);
      chk("pipe_rdata", bus.rdata_o, 64'(i));
    end
    bus.req_i = 1'b0;
    @(posedge clk);
    #1;
    chk("pipe_rvalid_end", 64'(bus.rvalid_o), 64'h0);
    chk("pipe_rdata_hold", bus.rdata_o, 64'h3);

    // Reset asserted during the MERGE cycle drops the write.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 8'h40; bus.wdata_i = 64'h55; bus.be_i = 8'h01;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    chk("mid_gnt_merge", 64'(bus.gnt_o), 64'h0);
    wr_before = sram_wr_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(sram_req), 64'h0);
    chk("mid_rst_cnt", 64'(rmw_cnt), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    chk("mid_gnt_after", 64'(bus.gnt_o), 64'h1);
    chk("mid_no_write", 64'(sram_wr_cnt), 64'(wr_before));
    v = '{1'b0, 8'h40, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA};
    run_vec(v);
    v = '{1'b1, 8'h40, 64'h55, 8'h01, 1'b1, 1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AA55};
    run_vec(v);
    v = '{1'b0, 8'h40, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 64'hAAAA_AAAA_AAAA_AA55};
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_rmw_ctrl.md
Name: sram_rmw_ctrl

Overview:
Request-side adapter placed directly upstream of the sram wrapper. The fakeram130 macros behind that wrapper have no byte-enable pin, so sram ignores be_i. This block accepts byte-enabled requests from the cache/core side and converts partial writes into a read-modify-write: one read, a merge, then one full-word write. Reads and full-mask writes pass through with one SRAM access each.

Parameters:
DATA_WIDTH, 64, word width in bits; must be a multiple of 8
NUM_WORDS, 256, SRAM depth, matching fakeram130_256x16
BE_WIDTH, DATA_WIDTH/8, derived; byte-enable width
ADDR_WIDTH, $clog2(NUM_WORDS), derived

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_i  in  1  upstream request valid
gnt_o  out  1  request accepted this cycle when req_i && gnt_o
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_WIDTH  word address
wdata_i  in  DATA_WIDTH  write data
be_i  in  BE_WIDTH  byte enables, bit k covers wdata_i[8k+7:8k]
rvalid_o  out  1  read data valid
rdata_o  out  DATA_WIDTH  read data
sram_req_o  out  1  to sram req_i
sram_we_o  out  1  to sram we_i
sram_addr_o  out  ADDR_WIDTH  to sram addr_i
sram_wdata_o  out  DATA_WIDTH  to sram wdata_i
sram_be_o  out  BE_WIDTH  to sram be_i; always all-ones
sram_rdata_i  in  DATA_WIDTH  from sram rdata_o; valid 1 cycle after a read request
rmw_cnt_o  out  32  partial-write counter (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high on rst_i; all state is cleared on assertion.
- FSM states: IDLE and MERGE. Reset value is IDLE.
- While rst_i is high: gnt_o=0, sram_req_o=0, rvalid_o=0, rmw_cnt_o=0.
- gnt_o = (state==IDLE) && !rst_i. The grant is combinational and does not depend on req_i.
- IDLE, accepted read:
  - Same cycle: sram_req_o=1, sram_we_o=0, sram_addr_o=addr_i.
  - Next cycle: rvalid_o=1 and rdata_o=sram_rdata_i.
  - Back-to-back reads sustain 1 per cycle with latency 1.
- IDLE, accepted write with be_i all-ones: same cycle sram_req_o=1, sram_we_o=1, sram_wdata_o=wdata_i. No rvalid. Stay in IDLE.
- IDLE, accepted write with be_i == 0:
  - Grant it, but issue no SRAM access (sram_req_o=0).
  - No rvalid, no count. Stay in IDLE.
- IDLE, accepted partial write (be_i nonzero and not all-ones):
  - Same cycle: issue an SRAM read of addr_i.
  - Register addr, wdata and be. Go to MERGE.
- MERGE:
  - gnt_o=0.
  - sram_req_o=1, sram_we_o=1, sram_addr_o=registered addr.
  - sram_wdata_o byte k = registered be[k] ? registered wdata byte k : sram_rdata_i byte k.
  - rvalid_o=0. Next state is IDLE.
  - A partial write therefore takes 2 cycles and gnt_o is low for exactly 1 cycle.
- Ordering: requests are strictly serialised. A read accepted right after a partial write sees the merged data, because the MERGE write completes before the grant returns.
- rdata_o holds its last value when rvalid_o=0; it is not required to be zero.
- No SRAM access when idle (req_i=0): sram_req_o=0.
- Reset asserted in MERGE: the pending write is dropped, state returns to IDLE, and the SRAM is not written. Software must treat that word as undefined.
- sram_be_o is driven all-ones at all times.

Optional Feature:
Macro SRAM_RMW_CNT_EN.
- Defined: 32-bit register counting entries into MERGE.
  - Increments by 1 on each partial-write acceptance.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst_i.
  - Driven on rmw_cnt_o.
- Undefined: no counter logic; rmw_cnt_o is tied to 32'h0.
- The port list is identical in both builds.

Test Plan:
- Full write then read: write addr 8'h10, data 64'h0123_4567_89AB_CDEF, be 8'hFF. Then read 8'h10 → gnt high both cycles, one SRAM access each, rvalid_o one cycle after the read grant, rdata_o=64'h0123_4567_89AB_CDEF.
- Partial write: preload 8'h20 = 64'hFFFF_FFFF_FFFF_FFFF. Write data 64'h0, be 8'h0F, then read 8'h20 → gnt low for exactly 1 cycle, SRAM sees read then write, readback 64'hFFFF_FFFF_0000_0000, rmw_cnt_o=1 (macro defined).
- Zero mask: write 8'h30, be 8'h00 → granted, sram_req_o stays 0, memory unchanged, rmw_cnt_o unchanged.
- Pipelined reads: 4 consecutive reads of addrs 0..3, preloaded with values 0..3 → 4 rvalid pulses on consecutive cycles, rdata_o = 0,1,2,3.
- Reset mid-RMW: preload 8'h40 = 64'hAAAA_AAAA_AAAA_AAAA. Partial write be 8'h01, data 64'h55, with rst_i pulsed in the MERGE cycle → no SRAM write, state IDLE, gnt_o high after release, readback of 8'h40 unchanged, rmw_cnt_o=0.
- Macro undefined build: rerun the partial-write scenario → rmw_cnt_o stays 32'h0 throughout.
